axi_mem_test_gen: RTL and testbench

- Synthesizable AXI4 master traffic generator and checker that sits directly upstream of sdram_axi and drives its inport_* AXI slave port.
- On start it writes NUM_BURSTS incrementing INCR bursts of an address-derived data pattern, then reads every burst back and compares each beat.
- It reports pass/fail, an error count and the address of the first failure.
- It replaces the behavioural AXI stimulus in ddr_system for on-silicon/FPGA memory test.

---
 rtl/axi_mem_test_gen_if.sv | 60 ++++++
 rtl/axi_mem_test_gen.sv | 273 +++++++++++++++++++++++++++
 tb/tb_axi_mem_test_gen.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_test_gen_if.sv
// AXI4 bundle between the memory test generator (master) and the memory port under test (slave).
interface axi_mem_test_gen_if;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awready;

    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wready;

    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bready;

    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arready;

    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rready;

    modport master (
        output awvalid, awaddr, awid, awlen, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arburst,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_mem_test_gen.sv
// AXI4 write-then-readback memory test generator with per-beat checking.
// Optional watchdog enabled by defining AXI_TEST_TIMEOUT_EN.
module axi_mem_test_gen #(
    parameter int unsigned NUM_BURSTS     = 256,
    parameter int unsigned BURST_LEN      = 8,
    parameter logic [31:0] ADDR_START     = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP      = 32'd32,
    parameter logic [31:0] DATA_SEED      = 32'h89AB_CDEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    axi_mem_test_gen_if.master outport,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic               timeout_o,
    output logic [15:0]        err_count_o,
    output logic [31:0]        first_err_addr_o
);

    localparam logic [7:0]  LenM1     = 8'(BURST_LEN - 1);
    localparam logic [31:0] LastBurst = 32'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StDone} state_e;

    state_e      state_q;
    logic [31:0] burst_addr_q;
    logic [31:0] burst_cnt_q;
    logic [7:0]  beat_q;

    logic        awvalid_q;
    logic [31:0] awaddr_q;
    logic [7:0]  awlen_q;
    logic        wvalid_q;
    logic [31:0] wdata_q;
    logic        wlast_q;
    logic        bready_q;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic        rready_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] err_count_q;
    logic [31:0] first_err_addr_q;

    logic [31:0] beat_addr;
    logic [31:0] next_beat_addr;
    logic [31:0] next_burst_addr;
    logic        last_beat;
    logic        last_burst;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        b_err, r_err, err_hit;
    logic [31:0] err_addr;
    logic        timeout_hit;

    assign beat_addr       = burst_addr_q + {22'd0, beat_q, 2'b00};
    assign next_beat_addr  = beat_addr + 32'd4;
    assign next_burst_addr = burst_addr_q + ADDR_STEP;
    assign last_beat       = (beat_q == LenM1);
    assign last_burst      = (burst_cnt_q == LastBurst);

    assign aw_hs = awvalid_q & outport.awready;
    assign w_hs  = wvalid_q & outport.wready;
    assign b_hs  = bready_q & outport.bvalid;
    assign ar_hs = arvalid_q & outport.arready;
    assign r_hs  = rready_q & outport.rvalid;

    // At most one error per beat: any of data, response or rlast placement being wrong.
    assign b_err = b_hs && (outport.bresp != 2'b00);
    assign r_err = r_hs && ((outport.rdata != (DATA_SEED + beat_addr)) ||
                            (outport.rresp != 2'b00) ||
                            (outport.rlast != last_beat));
    assign err_hit  = b_err | r_err | timeout_hit;
    assign err_addr = b_err ? burst_addr_q : beat_addr;

`ifdef AXI_TEST_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        timeout_q;
    logic        active;
    logic        any_hs;

    assign active      = (state_q == StAw) || (state_q == StW) || (state_q == StB) ||
                         (state_q == StAr) || (state_q == StR);
    assign any_hs      = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    assign timeout_hit = active && !any_hs && (wdog_q == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_o   = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= StIdle;
            burst_addr_q     <= 32'd0;
            burst_cnt_q      <= 32'd0;
            beat_q           <= 8'd0;
            awvalid_q        <= 1'b0;
            awaddr_q         <= 32'd0;
            awlen_q          <= 8'd0;
            wvalid_q         <= 1'b0;
            wdata_q          <= 32'd0;
            wlast_q          <= 1'b0;
            bready_q         <= 1'b0;
            arvalid_q        <= 1'b0;
            araddr_q         <= 32'd0;
            arlen_q          <= 8'd0;
            rready_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= 16'd0;
            first_err_addr_q <= 32'd0;
`ifdef AXI_TEST_TIMEOUT_EN
            wdog_q           <= 16'd0;
            timeout_q        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        err_count_q      <= 16'd0;
                        first_err_addr_q <= 32'd0;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        busy_q           <= 1'b1;
                        burst_addr_q     <= ADDR_START;
                        burst_cnt_q      <= 32'd0;
                        awvalid_q        <= 1'b1;
                        awaddr_q         <= ADDR_START;
                        awlen_q          <= LenM1;
                        state_q          <= StAw;
`ifdef AXI_TEST_TIMEOUT_EN
                        timeout_q        <= 1'b0;
`endif
                    end
                end
                StAw: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= DATA_SEED + burst_addr_q;
                        wlast_q   <= (LenM1 == 8'd0);
                        beat_q    <= 8'd0;
                        state_q   <= StW;
                    end
                end
                StW: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= StB;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            wdata_q <= DATA_SEED + next_beat_addr;
                            wlast_q <= ((beat_q + 8'd1) == LenM1);
                        end
                    end
                end
                StB: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        if (last_burst) begin
                            burst_addr_q <= ADDR_START;
                            burst_cnt_q  <= 32'd0;
                            arvalid_q    <= 1'b1;
                            araddr_q     <= ADDR_START;
                            arlen_q      <= LenM1;
                            state_q      <= StAr;
                        end else begin
                            burst_addr_q <= next_burst_addr;
                            burst_cnt_q  <= burst_cnt_q + 32'd1;
                            awvalid_q    <= 1'b1;
                            awaddr_q     <= next_burst_addr;
                            state_q      <= StAw;
                        end
                    end
                end
                StAr: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_q    <= 8'd0;
                        state_q   <= StR;
                    end
                end
                StR: begin
                    // The burst closes on the BURST_LEN-th beat whatever rlast says.
                    if (r_hs) begin
                        if (last_beat) begin
                            rready_q <= 1'b0;
                            if (last_burst) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= (err_count_q == 16'd0) && !r_err;
                                state_q <= StDone;
                            end else begin
                                burst_addr_q <= next_burst_addr;
                                burst_cnt_q  <= burst_cnt_q + 32'd1;
                                arvalid_q    <= 1'b1;
                                araddr_q     <= next_burst_addr;
                                state_q      <= StAr;
                            end
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (err_hit) begin
                if (err_count_q != 16'hFFFF) begin
                    err_count_q <= err_count_q + 16'd1;
                end
                if (err_count_q == 16'd0) begin
                    first_err_addr_q <= err_addr;
                end
            end

`ifdef AXI_TEST_TIMEOUT_EN
            if (!active || any_hs) begin
                wdog_q <= 16'd0;
            end else begin
                wdog_q <= wdog_q + 16'd1;
            end
            if (timeout_hit) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                wlast_q   <= 1'b0;
                bready_q  <= 1'b0;
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                timeout_q <= 1'b1;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                pass_q    <= 1'b0;
                state_q   <= StDone;
            end
`endif
        end
    end

    assign outport.awvalid = awvalid_q;
    assign outport.awaddr  = awaddr_q;
    assign outport.awid    = 4'd0;
    assign outport.awlen   = awlen_q;
    assign outport.awburst = 2'b01;
    assign outport.wvalid  = wvalid_q;
    assign outport.wdata   = wdata_q;
    assign outport.wstrb   = 4'hF;
    assign outport.wlast   = wlast_q;
    assign outport.bready  = bready_q;
    assign outport.arvalid = arvalid_q;
    assign outport.araddr  = araddr_q;
    assign outport.arid    = 4'd0;
    assign outport.arlen   = arlen_q;
    assign outport.arburst = 2'b01;
    assign outport.rready  = rready_q;

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_err_addr_q;

endmodule

// File: tb/tb_axi_mem_test_gen.sv
// Bench for axi_mem_test_gen: a memory slave plus an address/pattern model checked every cycle.
`timescale 1ns/1ps
module tb_axi_mem_test_gen;

    localparam int unsigned NB   = 4;
    localparam int unsigned BL   = 8;
    localparam logic [31:0] START = 32'h0000_0000;
    localparam logic [31:0] STEP  = 32'd32;
    localparam logic [31:0] SEED  = 32'h89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass, tmo;
    logic [15:0] err_count;
    logic [31:0] first_err;

    axi_mem_test_gen_if bus ();

    axi_mem_test_gen #(
        .NUM_BURSTS    (NB),
        .BURST_LEN     (BL),
        .ADDR_START    (START),
        .ADDR_STEP     (STEP),
        .DATA_SEED     (SEED),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .outport         (bus),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .timeout_o       (tmo),
        .err_count_o     (err_count),
        .first_err_addr_o(first_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return SEED + a;
    endfunction

    // Slave behaviour knobs
    bit stall_en = 0, corrupt_en = 0, bresp_en = 0, aw_block = 0;

    // Model of what the generator must do and what it must report
    int          aw_n, wr_k, b_n, ar_n, rd_k;
    logic [31:0] exp_err, exp_first;
    logic [31:0] wlog [0:31];
    logic [31:0] mem  [0:63];

    // Slave state
    logic [31:0] w_base, r_base;
    int          w_beat, r_beat;
    bit          b_pend, r_act;

    // DUT outputs as they stood before the coming edge
    bit          p_ok;
    logic        p_awv, p_wv, p_wlast, p_bready, p_arv, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [7:0]  p_awlen, p_arlen;
    logic [3:0]  p_awid, p_arid, p_wstrb;
    logic [1:0]  p_awburst, p_arburst;

    task automatic add_err(input logic [31:0] a);
        exp_err++;
        if (exp_err == 1) exp_first = a;
    endtask

    task automatic clear_model();
        aw_n = 0; wr_k = 0; b_n = 0; ar_n = 0; rd_k = 0;
        exp_err = 0; exp_first = 0;
    endtask

    task automatic drive_idle();
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.bid = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rid = 0;
        bus.rlast = 0;
    endtask

    function automatic bit coin();
        return !stall_en || ($urandom_range(0, 1) == 1);
    endfunction

    // Slave + compare process
    initial begin
        logic [31:0] a;
        drive_idle();
        p_ok = 0;
        b_pend = 0; r_act = 0; w_beat = 0; r_beat = 0; w_base = 0; r_base = 0;
        clear_model();
        forever begin
            @(posedge clk);
            if (rst) begin
                p_ok = 0; b_pend = 0; r_act = 0; w_beat = 0; r_beat = 0;
            end else if (p_ok) begin
                if (p_awv && bus.awready) begin
                    chk("awaddr", p_awaddr, START + aw_n * STEP);
                    chk("awlen", {24'd0, p_awlen}, BL - 1);
                    chk("awid", {28'd0, p_awid}, 0);
                    chk("awburst", {30'd0, p_awburst}, 1);
                    w_base = p_awaddr; w_beat = 0; aw_n++;
                end
                if (p_wv && bus.wready) begin
                    a = START + (wr_k / BL) * STEP + 4 * (wr_k % BL);
                    chk("wdata", p_wdata, pat(a));
                    chk("wlast", {31'd0, p_wlast}, (wr_k % BL) == BL - 1);
                    chk("wstrb", {28'd0, p_wstrb}, 32'hF);
                    mem[6'((w_base + 4 * w_beat) >> 2)] = p_wdata;
                    if (wr_k < 32) wlog[wr_k] = p_wdata;
                    w_beat++; wr_k++;
                    if (w_beat == BL) b_pend = 1;
                end
                if (p_bready && bus.bvalid) begin
                    if (bus.bresp != 2'b00) add_err(START + b_n * STEP);
                    b_pend = 0; b_n++;
                end
                if (p_arv && bus.arready) begin
                    chk("araddr", p_araddr, START + ar_n * STEP);
                    chk("arlen", {24'd0, p_arlen}, BL - 1);
                    chk("arid", {28'd0, p_arid}, 0);
                    chk("arburst", {30'd0, p_arburst}, 1);
                    r_base = p_araddr; r_beat = 0; r_act = 1; ar_n++;
                end
                if (p_rready && bus.rvalid) begin
                    a = r_base + 4 * r_beat;
                    if (bus.rdata != pat(a) || bus.rresp != 2'b00 ||
                        bus.rlast != (r_beat == BL - 1)) add_err(a);
                    r_beat++; rd_k++;
                    if (r_beat == BL) r_act = 0;
                end
            end
            #1;
            if (rst) begin
                drive_idle();
                p_ok = 0;
            end else begin
                if (p_ok && p_awv && !bus.awready) begin
                    chk("aw_hold_valid", {31'd0, bus.awvalid}, 1);
                    chk("aw_hold_addr", bus.awaddr, p_awaddr);
                end
                if (p_ok && p_wv && !bus.wready) begin
                    chk("w_hold_valid", {31'd0, bus.wvalid}, 1);
                    chk("w_hold_data", bus.wdata, p_wdata);
                end
                if (p_ok && p_arv && !bus.arready) begin
                    chk("ar_hold_addr", bus.araddr, p_araddr);
                end
                chk("aw_w_overlap", {31'd0, bus.awvalid & bus.wvalid}, 0);
                chk("ar_r_overlap", {31'd0, bus.arvalid & bus.rready}, 0);
                if (busy && !aw_block) begin
                    chk("err_count_live", {16'd0, err_count}, exp_err);
                    if (exp_err != 0) chk("first_err_live", first_err, exp_first);
                end
                // New slave drives for the coming edge
                bus.awready = aw_block ? 1'b0 : coin();
                bus.wready  = coin();
                bus.arready = coin();
                bus.bvalid  = b_pend && coin();
                bus.bresp   = (bresp_en && b_n == 2) ? 2'b10 : 2'b00;
                a = r_base + 4 * r_beat;
                bus.rvalid  = r_act && coin();
                bus.rdata   = mem[6'(a >> 2)] ^ ((corrupt_en && a == 32'h44) ? 32'd1 : 32'd0);
                bus.rresp   = 2'b00;
                bus.rlast   = (r_beat == BL - 1);
                p_awv = bus.awvalid; p_awaddr = bus.awaddr; p_awlen = bus.awlen;
                p_awid = bus.awid; p_awburst = bus.awburst;
                p_wv = bus.wvalid; p_wdata = bus.wdata; p_wlast = bus.wlast; p_wstrb = bus.wstrb;
                p_bready = bus.bready;
                p_arv = bus.arvalid; p_araddr = bus.araddr; p_arlen = bus.arlen;
                p_arid = bus.arid; p_arburst = bus.arburst;
                p_rready = bus.rready;
                p_ok = 1;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1;
        @(posedge clk);
        #1 start = 0;
        chk("aw_latency", {31'd0, bus.awvalid}, 1);
        chk("busy_after_start", {31'd0, busy}, 1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL %s_done_wait: done never rose, got 0 expected 1", tag);
        end
    endtask

    task automatic run_test(input bit st, input bit cor, input bit br,
                            input logic [31:0] want_err, input logic [31:0] want_first,
                            input bit want_pass, input string tag);
        stall_en = st; corrupt_en = cor; bresp_en = br; aw_block = 0;
        clear_model();
        pulse_start();
        wait_done(tag);
        chk({tag, "_done"}, {31'd0, done}, 1);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_pass"}, {31'd0, pass}, {31'd0, want_pass});
        chk({tag, "_err_count"}, {16'd0, err_count}, want_err);
        chk({tag, "_first_err"}, first_err, want_first);
        chk({tag, "_model_err"}, {16'd0, err_count}, exp_err);
        chk({tag, "_timeout"}, {31'd0, tmo}, 0);
        chk({tag, "_aw_count"}, aw_n, NB);
        chk({tag, "_w_count"}, wr_k, NB * BL);
        chk({tag, "_b_count"}, b_n, NB);
        chk({tag, "_ar_count"}, ar_n, NB);
        chk({tag, "_r_count"}, rd_k, NB * BL);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench stuck");
    end

    initial begin
        bit seen;
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", {31'd0, bus.awvalid}, 0);
        chk("rst_wvalid", {31'd0, bus.wvalid}, 0);
        chk("rst_bready", {31'd0, bus.bready}, 0);
        chk("rst_arvalid", {31'd0, bus.arvalid}, 0);
        chk("rst_rready", {31'd0, bus.rready}, 0);
        chk("rst_awaddr", bus.awaddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_pass", {31'd0, pass}, 0);
        chk("rst_timeout", {31'd0, tmo}, 0);
        chk("rst_err_count", {16'd0, err_count}, 0);
        chk("rst_first_err", first_err, 0);
        #2 rst = 0;

        // Always-ready memory, clean pattern
        run_test(0, 0, 0, 0, 0, 1, "clean");
        chk("wdata_beat0", wlog[0], 32'h89AB_CDEF);
        chk("wdata_beat9", wlog[9], 32'h89AB_CE13);

        // Single corrupted read beat at 0x44
        run_test(0, 1, 0, 1, 32'h44, 0, "corrupt");

        // Random stalls on every slave-driven handshake
        run_test(1, 0, 0, 0, 0, 1, "stall");

        // Error response on write burst 2
        run_test(0, 0, 1, 1, START + 2 * STEP, 0, "bresp");

        // Asynchronous reset in the middle of write beat 3
        stall_en = 0; corrupt_en = 0; bresp_en = 0; aw_block = 0;
        clear_model();
        pulse_start();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (wr_k == 3) begin
                seen = 1;
                break;
            end
        end
        chk("rst_mid_reached_beat3", {31'd0, seen}, 1);
        #2 rst = 1;
        #1;
        chk("rst_mid_wvalid", {31'd0, bus.wvalid}, 0);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        chk("rst_mid_done", {31'd0, done}, 0);
        repeat (2) @(posedge clk);
        #2 rst = 0;
        run_test(0, 0, 0, 0, 0, 1, "after_rst");

`ifdef AXI_TEST_TIMEOUT_EN
        // Write address never accepted: watchdog must end the test
        stall_en = 0; corrupt_en = 0; bresp_en = 0; aw_block = 1;
        clear_model();
        pulse_start();
        n = 0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (tmo) begin
                seen = 1;
                break;
            end
        end
        chk("to_seen", {31'd0, seen}, 1);
        chk("to_cycles", n, 16);
        chk("to_done", {31'd0, done}, 1);
        chk("to_pass", {31'd0, pass}, 0);
        chk("to_err_count", {16'd0, err_count}, 1);
        chk("to_awvalid", {31'd0, bus.awvalid}, 0);
        chk("to_busy", {31'd0, busy}, 0);
        aw_block = 0;
`else
        n = 0;
        seen = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
